writeback_scoreboard: RTL and testbench

WRITEBACK_SCOREBOARD -- requirements
Module: writeback_scoreboard

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_fifo.sv | 52 +++++
 rtl/writeback_scoreboard.sv | 126 ++++++++++++
 tb/tb_writeback_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the writeback entry carried through the load buffer.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREG       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  from_load;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for load results waiting for the register-file write port.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter type entry_t = cpu_pkg::wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[head_q];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= ptr_inc(tail_q);
      if (do_pop)  head_q <= ptr_inc(head_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/writeback_scoreboard.sv
// Register scoreboard plus single write-port arbiter for ALU results and buffered load responses.
module writeback_scoreboard #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned LDQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic            iss_is_load,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            wr_ena,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [NREG-1:0] busy
);
  import cpu_pkg::*;

  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_ena_q, wr_load_q;
  logic [4:0]      wr_addr_q;
  logic [XLEN-1:0] wr_data_q;

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t       push_entry, head_entry;

  logic            iss_accept, ld_accept, ld_keep;
  logic            alu_grant, head_grant, byp_grant, grant;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;
  logic            grant_load;

  always_comb begin
    iss_stall = iss_valid && (((iss_rs1 != '0) && busy_q[iss_rs1]) ||
                              ((iss_rs2 != '0) && busy_q[iss_rs2]) ||
                              ((iss_rd  != '0) && busy_q[iss_rd]));
  end

  assign iss_accept = iss_valid && !iss_stall;
  assign ld_ready   = !fifo_full && !rst;
  assign ld_accept  = ld_valid && ld_ready;
  // Loads to x0 are consumed here and never reach the buffer or write port.
  assign ld_keep    = ld_accept && (ld_rd != '0);

  always_comb begin
    alu_grant  = alu_valid && (alu_rd != '0);
    head_grant = !alu_grant && !fifo_empty;
    byp_grant  = !alu_grant && fifo_empty && ld_keep;
    grant      = alu_grant || head_grant || byp_grant;
    grant_rd   = '0;
    grant_data = '0;
    grant_load = 1'b0;
    if (alu_grant) begin
      grant_rd   = alu_rd;
      grant_data = alu_data;
    end else if (head_grant) begin
      grant_rd   = head_entry.rd;
      grant_data = head_entry.data;
      grant_load = head_entry.from_load;
    end else if (byp_grant) begin
      grant_rd   = ld_rd;
      grant_data = ld_data;
      grant_load = 1'b1;
    end
  end

  assign fifo_push  = ld_keep && !byp_grant;
  assign fifo_pop   = head_grant;
  assign push_entry = '{rd: ld_rd, data: ld_data, from_load: 1'b1};

  wb_fifo #(
    .Depth   (LDQ_DEPTH),
    .entry_t (wb_entry_t)
  ) u_ldq (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Clear lands one edge after the write so readers never see stale register-file data.
  always_comb begin
    busy_d = busy_q;
    if (wr_ena_q && wr_load_q) busy_d[wr_addr_q] = 1'b0;
    if (iss_accept && iss_is_load && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      wr_ena_q  <= 1'b0;
      wr_load_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      wr_ena_q  <= grant;
      wr_load_q <= grant && grant_load;
      if (grant) begin
        wr_addr_q <= grant_rd;
        wr_data_q <= grant_data;
      end
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed bench for writeback_scoreboard: hazards, arbitration, buffering, x0 handling, reset.
module tb_writeback_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_is_load;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_scoreboard #(
    .XLEN      (32),
    .NREG      (32),
    .LDQ_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_is_load (iss_is_load),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_stall   (iss_stall),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .wr_ena      (wr_ena),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_ena"}, 64'(wr_ena), 64'd1);
    check_eq({tag, "_addr"}, 64'(wr_addr), 64'(a));
    check_eq({tag, "_data"}, 64'(wr_data), 64'(d));
  endtask

  task automatic issue(input logic v, input logic ld, input logic [4:0] rd, input logic [4:0] rs1);
    iss_valid = v; iss_is_load = ld; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = '0;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic load(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v; ld_rd = rd; ld_data = d;
  endtask

  initial begin
    rst = 1'b1;
    issue(1'b0, 1'b0, 5'd0, 5'd0);
    alu(1'b0, 5'd0, 32'd0);
    load(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    // Reset state
    load(1'b1, 5'd3, 32'h1);
    #1;
    check_eq("rst_ld_ready", 64'(ld_ready), 64'd0);
    check_eq("rst_stall", 64'(iss_stall), 64'd0);
    check_eq("rst_wr_ena", 64'(wr_ena), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    load(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ld_ready", 64'(ld_ready), 64'd1);
    tick();

    // Load-use hazard on x5
    issue(1'b1, 1'b1, 5'd5, 5'd0);
    #1;
    check_eq("hz_first_stall", 64'(iss_stall), 64'd0);
    tick();
    check_eq("hz_busy_set", 64'(busy), 64'h20);
    issue(1'b1, 1'b0, 5'd1, 5'd5);
    load(1'b1, 5'd5, 32'h55);
    #1;
    check_eq("hz_stall_1", 64'(iss_stall), 64'd1);
    tick();
    load(1'b0, 5'd0, 32'd0);
    check_wr("hz_wr5", 5'd5, 32'h55);
    check_eq("hz_stall_2", 64'(iss_stall), 64'd1);
    tick();
    check_eq("hz_wr_idle", 64'(wr_ena), 64'd0);
    check_eq("hz_busy_clr", 64'(busy), 64'd0);
    check_eq("hz_stall_0", 64'(iss_stall), 64'd0);
    tick();
    check_eq("alu_issue_no_busy", 64'(busy), 64'd0);
    issue(1'b0, 1'b0, 5'd0, 5'd0);

    // ALU and load in the same cycle
    alu(1'b1, 5'd3, 32'hAAAA0000);
    load(1'b1, 5'd7, 32'h12345678);
    #1;
    check_eq("same_ready_a", 64'(ld_ready), 64'd1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    load(1'b0, 5'd0, 32'd0);
    check_wr("same_wr3", 5'd3, 32'hAAAA0000);
    check_eq("same_ready_b", 64'(ld_ready), 64'd1);
    tick();
    check_wr("same_wr7", 5'd7, 32'h12345678);
    tick();
    check_eq("same_idle", 64'(wr_ena), 64'd0);

    // ALU hogs the port for 4 cycles while 3 loads arrive
    alu(1'b1, 5'd10, 32'hA0);
    load(1'b1, 5'd20, 32'h100);
    #1; check_eq("hog_ready1", 64'(ld_ready), 64'd1);
    tick(); check_wr("hog_wr10", 5'd10, 32'hA0);
    alu(1'b1, 5'd11, 32'hA1);
    load(1'b1, 5'd21, 32'h101);
    #1; check_eq("hog_ready2", 64'(ld_ready), 64'd1);
    tick(); check_wr("hog_wr11", 5'd11, 32'hA1);
    alu(1'b1, 5'd12, 32'hA2);
    load(1'b1, 5'd22, 32'h102);
    #1; check_eq("hog_ready3", 64'(ld_ready), 64'd0);
    tick(); check_wr("hog_wr12", 5'd12, 32'hA2);
    alu(1'b1, 5'd13, 32'hA3);
    #1; check_eq("hog_ready4", 64'(ld_ready), 64'd0);
    tick(); check_wr("hog_wr13", 5'd13, 32'hA3);
    alu(1'b0, 5'd0, 32'd0);
    #1; check_eq("hog_ready5", 64'(ld_ready), 64'd0);
    tick(); check_wr("hog_wr20", 5'd20, 32'h100);
    check_eq("hog_ready6", 64'(ld_ready), 64'd1);
    tick(); check_wr("hog_wr21", 5'd21, 32'h101);
    load(1'b0, 5'd0, 32'd0);
    tick(); check_wr("hog_wr22", 5'd22, 32'h102);
    tick(); check_eq("hog_idle", 64'(wr_ena), 64'd0);

    // Writes to x0 are dropped; wr_addr/wr_data hold
    alu(1'b1, 5'd0, 32'hDEAD);
    load(1'b1, 5'd0, 32'hBEEF);
    #1; check_eq("x0_ready", 64'(ld_ready), 64'd1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    load(1'b0, 5'd0, 32'd0);
    check_eq("x0_wr_ena", 64'(wr_ena), 64'd0);
    check_eq("x0_busy", 64'(busy), 64'd0);
    check_eq("x0_addr_hold", 64'(wr_addr), 64'd22);
    check_eq("x0_data_hold", 64'(wr_data), 64'h102);
    tick();
    check_eq("x0_nothing_late", 64'(wr_ena), 64'd0);

    // Set busy[9] on the same edge busy[4] clears
    issue(1'b1, 1'b1, 5'd4, 5'd0);
    tick();
    check_eq("sc_busy4", 64'(busy), 64'h10);
    issue(1'b0, 1'b0, 5'd0, 5'd0);
    load(1'b1, 5'd4, 32'h44);
    tick();
    load(1'b0, 5'd0, 32'd0);
    check_wr("sc_wr4", 5'd4, 32'h44);
    issue(1'b1, 1'b1, 5'd9, 5'd0);
    #1; check_eq("sc_stall", 64'(iss_stall), 64'd0);
    tick();
    issue(1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("sc_busy9", 64'(busy), 64'h200);

    // Reset abandons buffered loads
    issue(1'b1, 1'b1, 5'd6, 5'd0);
    tick();
    issue(1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("rb_busy", 64'(busy), 64'h240);
    alu(1'b1, 5'd1, 32'h1);
    load(1'b1, 5'd6, 32'h66);
    tick(); check_wr("rb_wr1", 5'd1, 32'h1);
    alu(1'b1, 5'd2, 32'h2);
    load(1'b1, 5'd9, 32'h99);
    tick(); check_wr("rb_wr2", 5'd2, 32'h2);
    alu(1'b0, 5'd0, 32'd0);
    load(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1; check_eq("rb_ready_rst", 64'(ld_ready), 64'd0);
    tick();
    rst = 1'b0;
    check_eq("rb_busy0", 64'(busy), 64'd0);
    check_eq("rb_wr_ena0", 64'(wr_ena), 64'd0);
    check_eq("rb_wr_addr0", 64'(wr_addr), 64'd0);
    check_eq("rb_wr_data0", 64'(wr_data), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rb_no_late_wr", 64'(wr_ena), 64'd0);
      check_eq("rb_ready_after", 64'(ld_ready), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
